// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter that shifts a WIDTH-bit word MSB first.
// Latency: the MSB appears on sout the cycle after the load edge; done pulses the cycle after the last bit.
// Backpressure: load_ready is low while shifting; the optional parity cycle is enabled by PISO_TX_PARITY_EN.
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] din,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

`ifdef PISO_TX_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(NBITS);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_ready_q, load_ready_d;
`ifdef PISO_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: accept in IDLE, leave SHIFT once every bit (cnt_q counts bits driven) has been shown
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_valid) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; outputs are registered so the MSB is on sout right after the load edge
    always_comb begin
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        load_ready_d = 1'b1;
`ifdef PISO_TX_PARITY_EN
        par_d        = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    // MSB goes out immediately, the remaining bits wait left-aligned in the shifter
                    shreg_d      = din << 1;
                    cnt_d        = CW'(1);
                    sout_d       = din[WIDTH-1];
                    sout_valid_d = 1'b1;
                    busy_d       = 1'b1;
                    load_ready_d = 1'b0;
`ifdef PISO_TX_PARITY_EN
                    par_d        = ^din;
`endif
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    shreg_d = '0;
                end else begin
                    sout_valid_d = 1'b1;
                    busy_d       = 1'b1;
                    load_ready_d = 1'b0;
                    cnt_d        = cnt_q + 1'b1;
                    shreg_d      = shreg_q << 1;
`ifdef PISO_TX_PARITY_EN
                    sout_d       = (cnt_q == CW'(WIDTH)) ? par_q : shreg_q[WIDTH-1];
`else
                    sout_d       = shreg_q[WIDTH-1];
`endif
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers; reset clears everything and reopens the load port at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
        end
    end

`ifdef PISO_TX_PARITY_EN
    // Parity of the captured word, emitted after the data bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= par_d;
    end
`endif

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = load_ready_q;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: randomized and directed stimulus for piso_tx with a queue-based scoreboard.
// The reference model schedules each accepted word's bits and done pulse by cycle number.
// A separate monitor compares every output at each falling edge and on asynchronous reset.
module tb_piso_tx;
    localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] din = '0;
    logic         load_ready, sout, sout_valid, busy, done;

    piso_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .din        (din),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit b;
    } bit_t;

    bit_t bq[$];
    int   dq[$];
    int   cyc = 0;
    int   free_at = 0;
    int   tests = 0;
    int   fails = 0;
    bit   end_req = 1'b0;

    // Reference model: a word offered when the port is free is accepted; its bits occupy the next NB cycles
    initial begin
        logic [W-1:0] w;
        forever begin
            @(posedge clk);
            if (rst) begin
                bq.delete();
                dq.delete();
                free_at = 0;
            end else if (load_valid && cyc >= free_at) begin
                w = din;
                for (int k = 0; k < W; k++) bq.push_back('{cyc + 1 + k, w[W-1-k]});
`ifdef PISO_TX_PARITY_EN
                bq.push_back('{cyc + 1 + W, ^w});
`endif
                dq.push_back(cyc + NB + 1);
                free_at = cyc + NB + 1;
            end
            cyc++;
        end
    end

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endfunction

    // Monitor: compares outputs against the scoreboard queues
    initial begin
        bit   rdy_exp, v_exp, d_exp;
        bit_t e;
        while (!end_req) begin
            @(negedge clk or posedge rst);
            #1;
            if (rst) begin
                chk("rst_sout", int'(sout), 0);
                chk("rst_sout_valid", int'(sout_valid), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_load_ready", int'(load_ready), 1);
            end else begin
                rdy_exp = (cyc >= free_at);
                chk("load_ready", int'(load_ready), int'(rdy_exp));
                chk("busy", int'(busy), int'(!rdy_exp));
                v_exp = (bq.size() > 0 && bq[0].cyc == cyc);
                chk("sout_valid", int'(sout_valid), int'(v_exp));
                if (v_exp) begin
                    e = bq.pop_front();
                    chk("sout_bit", int'(sout), int'(e.b));
                end else begin
                    chk("sout_idle_zero", int'(sout), 0);
                end
                d_exp = (dq.size() > 0 && dq[0] == cyc);
                if (d_exp) void'(dq.pop_front());
                chk("done", int'(done), int'(d_exp));
            end
        end
        chk("bits_left", bq.size(), 0);
        chk("dones_left", dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_one(logic [W-1:0] v, int gap);
        load_valid = 1'b1;
        din = v;
        step();
        load_valid = 1'b0;
        step(gap);
    endtask

    // Stimulus
    initial begin
        step(3);
        rst = 1'b0;
        step();
        send_one(8'hA5, 12);
        send_one(8'h07, 12);
        send_one(8'hC0, 0);
        step(3);
        // Held load_valid: second word taken in the done cycle
        load_valid = 1'b1;
        din = 8'hFF;
        step(2);
        din = 8'h01;
        step(20);
        load_valid = 1'b0;
        step(12);
        // Offers during SHIFT are ignored
        load_valid = 1'b1;
        din = 8'hC3;
        step();
        din = 8'h00;
        step(3);
        load_valid = 1'b0;
        step(12);
        // Asynchronous reset during the 4th bit, then a fresh word
        load_valid = 1'b1;
        din = 8'h5A;
        step();
        load_valid = 1'b0;
        step(3);
        #2 rst = 1'b1;
        step(2);
        rst = 1'b0;
        send_one(8'h3C, 12);
        // Random traffic
        repeat (400) begin
            load_valid = 1'($urandom_range(0, 1));
            din = W'($urandom);
            step();
        end
        load_valid = 1'b0;
        step(15);
        end_req = 1'b1;
    end

endmodule
